// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, default
// parameter values and the round-robin pointer advance helper.
package mem_arbiter_pkg;

    localparam int NUM_CORES_DEF = 2;
    localparam int DATA_W_DEF    = 64;
    localparam int ADDR_W_DEF    = 16;
    localparam int TIMEOUT_DEF   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    // Priority pointer moves to the core just after the one served, with wrap.
    function automatic int rr_next(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Combinational round-robin selector: picks the first requesting core at or
// after the priority pointer, searching upward with wrap-around.
module rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Walk the cores starting at ptr; the first hit wins and masks later ones.
    always_comb begin
        logic [IDX_W-1:0] k_s;
        logic             hit_s;
        gnt   = {N{1'b0}};
        idx   = {IDX_W{1'b0}};
        vld   = 1'b0;
        k_s   = {IDX_W{1'b0}};
        hit_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            k_s      = IDX_W'((int'(ptr) + i) % N);
            hit_s    = req[k_s] & ~vld;
            gnt[k_s] = gnt[k_s] | hit_s;
            idx      = hit_s ? k_s : idx;
            vld      = vld | hit_s;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-core memory bus arbiter: round-robin grant, address/wait/done bus
// sequencing with active-low strobes, read data capture and wait timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [NUM_CORES-1:0]        Req,
    input  logic [NUM_CORES-1:0]        RnW_in,
    input  logic [NUM_CORES*ADDR_W-1:0] Addr_in,
    input  logic [NUM_CORES*DATA_W-1:0] Wdata_in,
    output logic [NUM_CORES-1:0]        Grant,
    output logic [NUM_CORES-1:0]        Done,
    output logic                        Err,
    output logic [DATA_W-1:0]           Rdata,
    output logic [ADDR_W-1:0]           Mem_addr,
    output logic [DATA_W-1:0]           Mem_wdata,
    input  logic [DATA_W-1:0]           Mem_rdata,
    input  logic                        Mem_ready,
    output logic                        nALE,
    output logic                        nME,
    output logic                        nOE,
    output logic                        RnW
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [NUM_CORES-1:0]   done_q, done_d;
    logic                   err_q, err_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   rnw_q, rnw_d;
    logic                   nale_q, nale_d;
    logic                   nme_q, nme_d;
    logic                   noe_q, noe_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_CORES-1:0]   sel_gnt_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic                   sel_vld_s;
    logic [ADDR_W-1:0]      addr_arr_s  [NUM_CORES];
    logic [DATA_W-1:0]      wdata_arr_s [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign addr_arr_s[g]  = Addr_in[g*ADDR_W +: ADDR_W];
        assign wdata_arr_s[g] = Wdata_in[g*DATA_W +: DATA_W];
    end

    rr_select #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req (Req),
        .ptr (ptr_q),
        .gnt (sel_gnt_s),
        .idx (sel_idx_s),
        .vld (sel_vld_s)
    );

    // Next-state and next-output logic; strobes are derived from the next
    // state so the registered strobes line up with the current state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        done_d  = {NUM_CORES{1'b0}};
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rnw_d   = rnw_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld_s) begin
                    state_d = ST_ADDR;
                    grant_d = sel_gnt_s;
                    gidx_d  = sel_idx_s;
                    addr_d  = addr_arr_s[sel_idx_s];
                    wdata_d = wdata_arr_s[sel_idx_s];
                    rnw_d   = RnW_in[sel_idx_s];
                end else begin
                    grant_d = {NUM_CORES{1'b0}};
                end
            end
            ST_ADDR: begin
                state_d = ST_WAIT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                // Mem_ready is checked first so it wins a same-cycle timeout.
                if (Mem_ready) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                    if (rnw_q) begin
                        rdata_d = Mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    cnt_d   = CNT_W'(TIMEOUT);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = {NUM_CORES{1'b0}};
                ptr_d   = IDX_W'(rr_next(int'(gidx_q), NUM_CORES));
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_CORES{1'b0}};
            end
        endcase
        nale_d = (state_d != ST_ADDR);
        nme_d  = (state_d != ST_WAIT);
        noe_d  = ~((state_d == ST_WAIT) & rnw_d);
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= {IDX_W{1'b0}};
            gidx_q  <= {IDX_W{1'b0}};
            grant_q <= {NUM_CORES{1'b0}};
            done_q  <= {NUM_CORES{1'b0}};
            err_q   <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rnw_q   <= 1'b1;
            nale_q  <= 1'b1;
            nme_q   <= 1'b1;
            noe_q   <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rnw_q   <= rnw_d;
            nale_q  <= nale_d;
            nme_q   <= nme_d;
            noe_q   <= noe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Grant     = grant_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign Rdata     = rdata_q;
    assign Mem_addr  = addr_q;
    assign Mem_wdata = wdata_q;
    assign nALE      = nale_q;
    assign nME       = nme_q;
    assign nOE       = noe_q;
    assign RnW       = rnw_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, timeout write,
// ready/timeout collision, mid-transaction reset, contention and a
// four-core round-robin run.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   rnw_in;
    logic [31:0]  addr_in;
    logic [127:0] wdata_in;
    logic [1:0]   grant;
    logic [1:0]   done;
    logic         err;
    logic [63:0]  rdata;
    logic [15:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_ready;
    logic         nale, nme, noe, rnw;

    logic         rst4;
    logic [3:0]   req4;
    logic [3:0]   rnw_in4;
    logic [63:0]  addr_in4;
    logic [255:0] wdata_in4;
    logic [3:0]   grant4;
    logic [3:0]   done4;
    logic         err4;
    logic [63:0]  rdata4;
    logic [15:0]  mem_addr4;
    logic [63:0]  mem_wdata4;
    logic [63:0]  mem_rdata4;
    logic         mem_ready4;
    logic         nale4, nme4, noe4, rnw4;

    int checks;
    int errors;

    mem_arbiter dut (
        .Clock     (clk),
        .Reset     (rst),
        .Req       (req),
        .RnW_in    (rnw_in),
        .Addr_in   (addr_in),
        .Wdata_in  (wdata_in),
        .Grant     (grant),
        .Done      (done),
        .Err       (err),
        .Rdata     (rdata),
        .Mem_addr  (mem_addr),
        .Mem_wdata (mem_wdata),
        .Mem_rdata (mem_rdata),
        .Mem_ready (mem_ready),
        .nALE      (nale),
        .nME       (nme),
        .nOE       (noe),
        .RnW       (rnw)
    );

    mem_arbiter #(.NUM_CORES(4)) dut4 (
        .Clock     (clk),
        .Reset     (rst4),
        .Req       (req4),
        .RnW_in    (rnw_in4),
        .Addr_in   (addr_in4),
        .Wdata_in  (wdata_in4),
        .Grant     (grant4),
        .Done      (done4),
        .Err       (err4),
        .Rdata     (rdata4),
        .Mem_addr  (mem_addr4),
        .Mem_wdata (mem_wdata4),
        .Mem_rdata (mem_rdata4),
        .Mem_ready (mem_ready4),
        .nALE      (nale4),
        .nME       (nme4),
        .nOE       (noe4),
        .RnW       (rnw4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [3:0]  exp_g4;
        logic [15:0] exp_a;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        rst4       = 1'b1;
        req        = 2'b00;
        rnw_in     = 2'b00;
        addr_in    = 32'h0;
        wdata_in   = 128'h0;
        mem_rdata  = 64'h0;
        mem_ready  = 1'b0;
        req4       = 4'b0000;
        rnw_in4    = 4'b0000;
        addr_in4   = 64'h0;
        wdata_in4  = 256'h0;
        mem_rdata4 = 64'h0;
        mem_ready4 = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_grant", 64'(grant), 64'(2'b00));
        check("rst_done", 64'(done), 64'(2'b00));
        check("rst_err", 64'(err), 64'(1'b0));
        check("rst_rdata", rdata, 64'h0);
        check("rst_addr", 64'(mem_addr), 64'h0);
        check("rst_wdata", mem_wdata, 64'h0);
        check("rst_nale", 64'(nale), 64'(1'b1));
        check("rst_nme", 64'(nme), 64'(1'b1));
        check("rst_noe", 64'(noe), 64'(1'b1));
        check("rst_rnw", 64'(rnw), 64'(1'b1));
        check("rst4_grant", 64'(grant4), 64'(4'b0000));
        rst  = 1'b0;
        rst4 = 1'b0;

        // Single read from core 0, ready on the first WAIT cycle
        req       = 2'b01;
        rnw_in    = 2'b01;
        addr_in   = 32'h0000_0040;
        mem_ready = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_0000_0001;
        tick();
        check("rd_addr_grant", 64'(grant), 64'(2'b01));
        check("rd_addr_nale", 64'(nale), 64'(1'b0));
        check("rd_addr_nme", 64'(nme), 64'(1'b1));
        check("rd_addr_memaddr", 64'(mem_addr), 64'h0040);
        check("rd_addr_rnw", 64'(rnw), 64'(1'b1));
        req = 2'b00;
        tick();
        check("rd_wait_nme", 64'(nme), 64'(1'b0));
        check("rd_wait_noe", 64'(noe), 64'(1'b0));
        check("rd_wait_nale", 64'(nale), 64'(1'b1));
        check("rd_wait_done", 64'(done), 64'(2'b00));
        tick();
        check("rd_done_done", 64'(done), 64'(2'b01));
        check("rd_done_err", 64'(err), 64'(1'b0));
        check("rd_done_rdata", rdata, 64'hDEAD_BEEF_0000_0001);
        check("rd_done_grant", 64'(grant), 64'(2'b01));
        mem_rdata = 64'h0;
        tick();
        check("rd_idle_done", 64'(done), 64'(2'b00));
        check("rd_idle_grant", 64'(grant), 64'(2'b00));
        check("rd_idle_rdata", rdata, 64'hDEAD_BEEF_0000_0001);

        // Timeout write from core 1 (pointer now at 1)
        req       = 2'b10;
        rnw_in    = 2'b00;
        addr_in   = 32'h0200_0040;
        wdata_in  = {64'h1234_5678_9ABC_DEF0, 64'h0};
        mem_ready = 1'b0;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("to_grant", 64'(grant), 64'(2'b10));
        check("to_memaddr", 64'(mem_addr), 64'h0200);
        check("to_wdata", mem_wdata, 64'h1234_5678_9ABC_DEF0);
        check("to_rnw", 64'(rnw), 64'(1'b0));
        req = 2'b00;
        tick();
        for (int i = 0; i < 15; i++) begin
            check("to_wait_nme", 64'(nme), 64'(1'b0));
            check("to_wait_noe", 64'(noe), 64'(1'b1));
            check("to_wait_done", 64'(done), 64'(2'b00));
            tick();
        end
        check("to_done_done", 64'(done), 64'(2'b10));
        check("to_done_err", 64'(err), 64'(1'b1));
        check("to_done_nme", 64'(nme), 64'(1'b1));
        check("to_done_rdata", rdata, 64'hDEAD_BEEF_0000_0001);
        tick();
        check("to_idle_err", 64'(err), 64'(1'b0));
        check("to_idle_done", 64'(done), 64'(2'b00));

        // Ready arrives on the same WAIT cycle the timeout would fire
        req       = 2'b01;
        rnw_in    = 2'b01;
        addr_in   = 32'h0200_0080;
        mem_ready = 1'b0;
        mem_rdata = 64'hCAFE_F00D_0000_0002;
        tick();
        check("col_grant", 64'(grant), 64'(2'b01));
        req = 2'b00;
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check("col_wait15_nme", 64'(nme), 64'(1'b0));
        mem_ready = 1'b1;
        tick();
        check("col_done_done", 64'(done), 64'(2'b01));
        check("col_done_err", 64'(err), 64'(1'b0));
        check("col_done_rdata", rdata, 64'hCAFE_F00D_0000_0002);
        mem_ready = 1'b0;
        tick();

        // Reset asserted in WAIT of a core 1 read (pointer at 1 before reset)
        req    = 2'b10;
        rnw_in = 2'b10;
        tick();
        check("mr_grant", 64'(grant), 64'(2'b10));
        tick();
        check("mr_wait_nme", 64'(nme), 64'(1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b00;
        check("mr_nale", 64'(nale), 64'(1'b1));
        check("mr_nme", 64'(nme), 64'(1'b1));
        check("mr_noe", 64'(noe), 64'(1'b1));
        check("mr_done", 64'(done), 64'(2'b00));
        check("mr_grant0", 64'(grant), 64'(2'b00));
        tick();
        check("mr_done_after", 64'(done), 64'(2'b00));

        // Contention: both cores held; first grant to core 0 shows P was reset
        req       = 2'b11;
        rnw_in    = 2'b00;
        addr_in   = 32'h0111_0100;
        wdata_in  = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        mem_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (t % 2 == 0) ? 16'h0100 : 16'h0111;
            tick();
            check("ct_grant", 64'(grant), 64'(exp_g));
            check("ct_memaddr", 64'(mem_addr), 64'(exp_a));
            tick();
            tick();
            check("ct_done", 64'(done), 64'(exp_g));
            check("ct_err", 64'(err), 64'(1'b0));
            tick();
            check("ct_idle_done", 64'(done), 64'(2'b00));
        end
        req = 2'b00;
        tick();

        // Four-core instance, cores 1 and 3 held
        req4       = 4'b1010;
        mem_ready4 = 1'b1;
        addr_in4   = {16'h300A, 16'h200A, 16'h100A, 16'h000A};
        for (int t = 0; t < 3; t++) begin
            exp_g4 = (t == 1) ? 4'b1000 : 4'b0010;
            exp_a  = (t == 1) ? 16'h300A : 16'h100A;
            tick();
            check("p4_grant", 64'(grant4), 64'(exp_g4));
            check("p4_memaddr", 64'(mem_addr4), 64'(exp_a));
            tick();
            tick();
            check("p4_done", 64'(done4), 64'(exp_g4));
            tick();
        end
        req4 = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
